// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with in-order request tracking and redirect flush
//
// Purpose: issues word-aligned instruction memory requests from a fetch PC,
// tracks outstanding requests in order, buffers returned instructions in a
// DEPTH-entry FIFO and presents them to decode. A jump redirects the PC,
// clears the buffer and drops every response still in flight.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-low reset
//   jump_flag_i   redirect request from ex
//   jump_addr_i   redirect target (low two bits ignored)
//   mem_req_o     instruction memory request
//   mem_addr_o    request address (word aligned)
//   mem_gnt_i     request accepted when mem_req_o & mem_gnt_i
//   mem_rvalid_i  in-order response valid
//   mem_rdata_i   response instruction word
//   inst_o        instruction to id (NOP_INST when nothing valid)
//   inst_addr_o   address of inst_o (last presented address when idle)
//   inst_valid_o  inst_o / inst_addr_o valid
//   inst_ready_i  id accepts; transfer on inst_valid_o & inst_ready_i
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_pc;
    logic [31:0]     r_last_addr;
    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_fifo_cnt;
    logic [PW-1:0]   r_fifo_rd;
    logic [PW-1:0]   r_fifo_wr;
    logic [PW-1:0]   r_aq_rd;
    logic [PW-1:0]   r_aq_wr;
    logic [31:0]     r_fifo_inst [DEPTH];
    logic [31:0]     r_fifo_addr [DEPTH];
    logic [31:0]     r_aq        [DEPTH];

    logic            w_grant;
    logic            w_resp;
    logic            w_resp_drop;
    logic            w_push;
    logic            w_pop;
    logic [CW:0]     w_occ_sum;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [31:0]     w_head_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Dropped (stale) responses still occupy request slots, so the limit
    // counts them until they come back.
    assign w_occ_sum    = {1'b0, r_fifo_cnt} + {1'b0, r_out_cnt};
    assign mem_req_o    = rst & ~jump_flag_i & (w_occ_sum < {1'b0, DEPTH_C});
    assign mem_addr_o   = r_pc;

    assign w_grant      = mem_req_o & mem_gnt_i;
    // A response with nothing outstanding cannot be attributed; ignore it.
    assign w_resp       = mem_rvalid_i & (r_out_cnt != '0);
    assign w_resp_drop  = w_resp & (r_state == ST_FLUSH);
    assign w_push       = w_resp & (r_state == ST_RUN) & ~jump_flag_i;
    assign w_pop        = inst_valid_o & inst_ready_i & ~jump_flag_i;
    assign w_out_nxt    = r_out_cnt + CW'(w_grant) - CW'(w_resp);

    assign w_head_addr  = r_fifo_addr[r_fifo_rd];
    assign inst_valid_o = (r_fifo_cnt != '0);
    assign inst_o       = inst_valid_o ? r_fifo_inst[r_fifo_rd] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? w_head_addr : r_last_addr;

    // FLUSH lasts exactly as long as responses remain to be discarded; a
    // jump reloads the count with whatever is still in flight after this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (jump_flag_i) begin
            w_drop_nxt  = w_out_nxt;
            w_state_nxt = (w_out_nxt != '0) ? ST_FLUSH : ST_RUN;
        end else if (w_resp_drop) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
            if (r_drop_cnt == CW'(1)) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_last_addr <= RESET_PC;
            r_out_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_fifo_cnt  <= '0;
            r_fifo_rd   <= '0;
            r_fifo_wr   <= '0;
            r_aq_rd     <= '0;
            r_aq_wr     <= '0;
        end else begin
            r_out_cnt  <= w_out_nxt;
            r_drop_cnt <= w_drop_nxt;

            if (jump_flag_i) begin
                r_pc <= jump_addr_i & 32'hFFFF_FFFC;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end

            // The address queue is never cleared by a jump: dropped
            // responses still consume their entries in order.
            if (w_grant) begin
                r_aq_wr <= ptr_inc(r_aq_wr);
            end
            if (w_resp) begin
                r_aq_rd <= ptr_inc(r_aq_rd);
            end

            if (jump_flag_i) begin
                r_fifo_cnt <= '0;
                r_fifo_rd  <= '0;
                r_fifo_wr  <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_wr <= ptr_inc(r_fifo_wr);
                end
                if (w_pop) begin
                    r_fifo_rd <= ptr_inc(r_fifo_rd);
                end
                r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
            end

            if (inst_valid_o) begin
                r_last_addr <= w_head_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_aq[r_aq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_inst[r_fifo_wr] <= mem_rdata_i;
            r_fifo_addr[r_fifo_wr] <= r_aq[r_aq_rd];
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    logic        jf2, gnt2, ready2, rvalid2, req2, ivalid2;
    logic [31:0] ja2, rdata2, addr2, inst2, iaddr2;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_grants = 0;
    int n_deliv  = 0;

    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    bit          rv_sol    = 0;
    bit          resp_hold = 0;
    bit          force_rv  = 0;
    bit          zero_next = 0;
    logic [31:0] exp_addr  = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;

    logic [31:0] q2[$];
    bit          g2_seen = 0;
    logic [31:0] g2_addr = 32'h0;
    int          g0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP)) u_dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
    );

    if_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH), .NOP_INST(NOP)) u_dut_wrap (
        .clk(clk), .rst(rst), .jump_flag_i(jf2), .jump_addr_i(ja2),
        .mem_req_o(req2), .mem_addr_o(addr2), .mem_gnt_i(gnt2),
        .mem_rvalid_i(rvalid2), .mem_rdata_i(rdata2), .inst_o(inst2),
        .inst_addr_o(iaddr2), .inst_valid_o(ivalid2), .inst_ready_i(ready2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    endtask

    // One cycle: wait for the edge, then drive this cycle's memory response.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        jump_flag_i = 1'b0;
        if (force_rv) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            rv_sol       = 1'b0;
            force_rv     = 1'b0;
        end else if (!resp_hold && pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memf(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
            rv_sol       = 1'b1;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            rv_sol       = 1'b0;
        end
    endtask

    // Reference model: after reset or a jump to T, fetches and deliveries are
    // T, T+4, T+8, ... in order, each carrying memory contents at its address.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req", mem_req_o, 0);
            chk("rst_valid", inst_valid_o, 0);
            chk("rst_inst", inst_o, NOP);
            chk("rst_iaddr", inst_addr_o, RESET_PC);
            exp_addr  = RESET_PC;
            exp_fetch = RESET_PC;
            zero_next = 0;
            pend_addr.delete();
            pend_cyc.delete();
        end else begin
            if (zero_next) chk("valid_after_jump", inst_valid_o, 0);
            zero_next = jump_flag_i;
            if (!inst_valid_o) chk("nop_when_idle", inst_o, NOP);
            if (jump_flag_i) chk("no_req_on_jump", mem_req_o, 0);
            if (pend_addr.size() + int'(rv_sol) >= DEPTH) chk("req_limit", mem_req_o, 0);
            if (mem_req_o) chk("fetch_addr", mem_addr_o, exp_fetch);
            if (inst_valid_o && inst_ready_i && !jump_flag_i) begin
                chk("deliv_addr", inst_addr_o, exp_addr);
                chk("deliv_inst", inst_o, memf(exp_addr));
                exp_addr += 32'd4;
                n_deliv++;
            end
            if (mem_req_o && mem_gnt_i) begin
                pend_addr.push_back(mem_addr_o);
                pend_cyc.push_back(cyc);
                exp_fetch += 32'd4;
                n_grants++;
            end
            if (jump_flag_i) begin
                exp_addr  = jump_addr_i & 32'hFFFF_FFFC;
                exp_fetch = jump_addr_i & 32'hFFFF_FFFC;
            end
        end
    end

    // Second instance: fixed-latency memory, collect first three deliveries.
    always @(negedge clk) begin
        if (!rst) begin
            g2_seen = 0;
        end else begin
            g2_seen = req2 && gnt2;
            g2_addr = addr2;
            if (ivalid2 && ready2 && q2.size() < 3) begin
                q2.push_back(iaddr2);
                chk("wrap_inst", inst2, memf(iaddr2));
            end
        end
    end

    initial begin
        rvalid2 = 1'b0;
        rdata2  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            rvalid2 = g2_seen;
            rdata2  = memf(g2_addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; inst_ready_i = 1'b1;
        jf2 = 1'b0; ja2 = 32'h0; gnt2 = 1'b1; ready2 = 1'b1;
        repeat (3) step();

        // Streaming fetch, gnt tied high, one-cycle memory
        rst = 1'b1;
        #1;
        chk("first_req", mem_req_o, 1);
        chk("first_addr", mem_addr_o, RESET_PC);
        step();
        chk("latency_c1_valid", inst_valid_o, 0);
        step();
        chk("latency_c2_valid", inst_valid_o, 1);
        chk("latency_c2_addr", inst_addr_o, 32'h0);
        step();
        chk("stream_c3_addr", inst_addr_o, 32'h4);
        repeat (20) step();

        // Asynchronous reset mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", mem_req_o, 0);
        chk("async_valid", inst_valid_o, 0);
        chk("async_inst", inst_o, NOP);
        chk("async_iaddr", inst_addr_o, RESET_PC);
        step();
        step();

        // Back-pressure: ready low for 10 cycles
        inst_ready_i = 1'b0;
        rst = 1'b1;
        g0 = n_grants;
        repeat (10) step();
        chk("bp_grants", n_grants - g0, 2);
        chk("bp_req_off", mem_req_o, 0);
        chk("bp_head_valid", inst_valid_o, 1);
        chk("bp_head_addr", inst_addr_o, 32'h0);
        inst_ready_i = 1'b1;
        step();
        chk("bp_second_addr", inst_addr_o, 32'h4);
        repeat (10) step();

        // Jump with two requests outstanding
        resp_hold = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (pend_addr.size() == 2 && !inst_valid_o) break;
            step();
        end
        chk("jump1_setup", (pend_addr.size() == 2 && !inst_valid_o), 1);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0103;
        resp_hold   = 1'b0;
        step();
        for (int k = 0; k < 20; k++) begin
            if (inst_valid_o) break;
            step();
        end
        chk("jump1_first_addr", inst_addr_o, 32'h0000_0100);
        chk("jump1_first_inst", inst_o, memf(32'h0000_0100));
        repeat (6) step();

        // Second jump while still flushing; a request to 0x100 is in flight
        resp_hold = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (pend_addr.size() == 2 && !inst_valid_o) break;
            step();
        end
        chk("jump2_setup", (pend_addr.size() == 2 && !inst_valid_o), 1);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        resp_hold   = 1'b0;
        step();
        resp_hold = 1'b1;
        step();
        chk("flush_req", mem_req_o, 1);
        chk("flush_req_addr", mem_addr_o, 32'h0000_0100);
        step();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0200;
        resp_hold   = 1'b0;
        step();
        for (int k = 0; k < 20; k++) begin
            if (inst_valid_o) break;
            step();
        end
        chk("jump2_first_addr", inst_addr_o, 32'h0000_0200);
        repeat (6) step();

        // Unsolicited response with nothing outstanding
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (pend_addr.size() == 0 && !inst_valid_o && !mem_rvalid_i) break;
            step();
        end
        chk("idle_setup", (pend_addr.size() == 0 && !inst_valid_o), 1);
        force_rv = 1'b1;
        step();
        step();
        chk("unsolicited_ignored", inst_valid_o, 0);
        mem_gnt_i = 1'b1;
        repeat (10) step();

        // PC wrap instance
        chk("wrap_count", (q2.size() >= 3), 1);
        chk("wrap_addr0", q2[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", q2[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", q2[2], 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries, also the maximum number of outstanding memory requests.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): value driven on inst_o while no instruction is valid.
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: jump_flag_i  in  1  redirect request from ex.
REQ-007 SHALL have port: jump_addr_i  in  32  redirect target.
REQ-008 SHALL have port: mem_req_o  out  1  instruction memory request.
REQ-009 SHALL have port: mem_addr_o  out  32  request address, word aligned.
REQ-010 SHALL have port: mem_gnt_i  in  1  request accepted when mem_req_o and mem_gnt_i are both high.
REQ-011 SHALL have port: mem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-012 SHALL have port: mem_rdata_i  in  32  response instruction word.
REQ-013 SHALL have port: inst_o  out  32  instruction to id.
REQ-014 SHALL have port: inst_addr_o  out  32  address of inst_o.
REQ-015 SHALL have port: inst_valid_o  out  1  inst_o/inst_addr_o valid.
REQ-016 SHALL have port: inst_ready_i  in  1  id accepts; transfer when inst_valid_o and inst_ready_i are both high.

Function
REQ-017 SHALL hold a fetch PC register; PC advances by 4 on each grant.
REQ-018 SHALL assert mem_req_o only when (buffer occupancy + outstanding requests) < DEPTH and no jump_flag_i is present that cycle; mem_addr_o = PC.
REQ-019 SHALL keep mem_req_o and mem_addr_o stable until grant, unless a jump occurs.
REQ-020 SHALL push {address, mem_rdata_i} into a DEPTH-entry FIFO on each mem_rvalid_i whose response is not being dropped; the address is taken from an in-order outstanding-address queue.
REQ-021 SHALL drive FIFO head on inst_o/inst_addr_o with inst_valid_o=1 when not empty; when empty, inst_o=NOP_INST, inst_addr_o=last presented address, inst_valid_o=0.
REQ-022 SHALL give a latency of 1 cycle from a kept mem_rvalid_i to inst_valid_o=1 with an empty buffer (registered FIFO, no bypass).
REQ-023 SHALL allow a simultaneous push and pop when full; occupancy is unchanged.
REQ-024 SHALL implement a two-state FSM. RUN is the normal state. FLUSH is entered on jump_flag_i while any response is outstanding, and stays there until the drop count reaches 0.
REQ-025 SHALL, on jump_flag_i: clear the FIFO; set PC = {jump_addr_i[31:2],2'b00}; set drop count = outstanding after this cycle's grant and response are accounted; drive inst_valid_o=0 in the following cycle.
REQ-026 SHALL discard mem_rvalid_i while drop count > 0, decrementing the count; new requests are permitted during FLUSH.
REQ-027 SHALL let a jump in FLUSH reload the drop count with the current outstanding total; PC takes the newest target.
REQ-028 SHALL give jump priority over a same-cycle pop, push or grant-driven PC increment; a grant in the jump cycle is counted for dropping.
REQ-029 SHALL keep the outstanding counter and drop counter wide enough for DEPTH; neither may underflow or overflow. An unsolicited rvalid with zero outstanding is ignored.
REQ-030 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-031 SHALL, while rst=0: PC=RESET_PC, FIFO empty, counters 0, FSM=RUN, mem_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=RESET_PC.
REQ-032 SHALL take reset asynchronously, including mid-transaction; responses to requests granted before reset are not dropped and may be accepted if they arrive after deassertion.
REQ-033 SHALL assert mem_req_o in the first cycle after rst deasserts.

Verification
REQ-034 SHALL be tested by: reset release, gnt tied 1, rvalid 1 cycle after each grant, ready=1 -> inst_addr_o sequence 0,4,8,... with inst_o equal to the memory contents.
REQ-035 SHALL be tested by: ready=0 for 10 cycles -> exactly 2 grants, then mem_req_o=0; FIFO holds 0 and 4; on ready=1, addresses 0,4,8 are delivered without gaps.
REQ-036 SHALL be tested by: jump_flag_i with jump_addr_i=32'h0000_0103 while 2 requests are outstanding -> both responses dropped; next delivered inst_addr_o=32'h0000_0100.
REQ-037 SHALL be tested by: a second jump to 32'h200 during FLUSH -> no instruction from 0x100 is delivered; the first delivered address is 0x200.
REQ-038 SHALL be tested by: RESET_PC=32'hFFFF_FFF8 -> delivered addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 SHALL be tested by: rst pulsed low mid-run -> all REQ-031 values appear within the same cycle, before any clock edge.
